ntt_bitrev_reorder: RTL

//  Output reorder stage after the last SDF NTT butterfly/Montgomery stage.

---
 rtl/ntt_bitrev_reorder.sv | 102 ++++++++++
 1 files changed

// File: rtl/ntt_bitrev_reorder.sv
// Bit-reversed to natural order reorder stage after the final NTT butterfly.
// Ping-pong banks: one fills while the other drains through a valid/ready register.
module ntt_bitrev_reorder #(
    parameter int W = 32,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         overflow
);
    localparam int LOGN = $clog2(N);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [W-1:0]    mem [2*N];
    logic            wr_bank;
    logic            rd_bank;
    logic [LOGN-1:0] wr_cnt;
    logic [LOGN-1:0] rd_cnt;
    logic [1:0]      bank_full;
    logic [0:0]      state;
    logic            accept;
    logic            load;
    logic            wr_wrap;
    logic            rd_wrap;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = x[LOGN-1-i];
        end
        return r;
    endfunction

    assign in_ready = !bank_full[wr_bank];
    assign accept   = in_valid && in_ready;
    assign wr_wrap  = accept && (wr_cnt == LOGN'(N - 1));

    // A full bank loads even from IDLE so index 0 lands two cycles after the last write
    assign load    = bank_full[rd_bank] && (!out_valid || out_ready);
    assign rd_wrap = load && (rd_cnt == LOGN'(N - 1));

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            bank_full <= 2'b00;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_wrap) begin
                    wr_bank            <= ~wr_bank;
                    bank_full[wr_bank] <= 1'b1;
                end
            end
            if (load) begin
                out_data  <= mem[{rd_bank, rd_cnt}];
                out_last  <= rd_wrap;
                out_valid <= 1'b1;
                rd_cnt    <= rd_cnt + 1'b1;
                if (rd_wrap) begin
                    rd_bank            <= ~rd_bank;
                    bank_full[rd_bank] <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            unique case (1'b1)
                state == IDLE: begin
                    if (bank_full[rd_bank]) state <= DRAIN;
                end
                state == DRAIN: begin
                    if (rd_wrap) state <= bank_full[~rd_bank] ? DRAIN : IDLE;
                end
            endcase
        end
    end
endmodule
